// File: rtl/traffic_light_ctrl.sv
// Two-direction traffic light sequencer driven by a synchronised 1 Hz square wave.
// Optional night flashing mode is enabled by defining TRAFFIC_NIGHT_MODE_EN.
module traffic_light_ctrl #(
    parameter int GREEN_S  = 25,
    parameter int YELLOW_S = 3,
    parameter int ALLRED_S = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_1hz,
`ifdef TRAFFIC_NIGHT_MODE_EN
    input  logic             night_mode,
`endif
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [CNT_W-1:0] sec_left,
    output logic [2:0]       phase
);

    localparam logic [2:0] NS_GREEN  = 3'd0;
    localparam logic [2:0] NS_YELLOW = 3'd1;
    localparam logic [2:0] ALL_RED_A = 3'd2;
    localparam logic [2:0] EW_GREEN  = 3'd3;
    localparam logic [2:0] EW_YELLOW = 3'd4;
    localparam logic [2:0] ALL_RED_B = 3'd5;
    localparam logic [2:0] FLASH     = 3'd6;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_S);

    logic             sync_p0, sync_p1, prev_p2, tick_p3;
    logic             night_act;
    logic [2:0]       phase_q, phase_d;
    logic [CNT_W-1:0] sec_q, sec_d;
    logic [2:0]       ns_q, ns_d, ew_q, ew_d;

    function automatic logic [CNT_W-1:0] duration(input logic [2:0] ph);
        case (ph)
            NS_GREEN, EW_GREEN:   duration = CNT_W'(GREEN_S);
            NS_YELLOW, EW_YELLOW: duration = CNT_W'(YELLOW_S);
            default:              duration = ALLRED_LOAD;
        endcase
    endfunction

    function automatic logic [2:0] successor(input logic [2:0] ph);
        case (ph)
            NS_GREEN:  successor = NS_YELLOW;
            NS_YELLOW: successor = ALL_RED_A;
            ALL_RED_A: successor = EW_GREEN;
            EW_GREEN:  successor = EW_YELLOW;
            EW_YELLOW: successor = ALL_RED_B;
            default:   successor = NS_GREEN;
        endcase
    endfunction

    // Synchroniser and edge detector; preset high so reset release never looks like a rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b1;
            tick_p3 <= 1'b0;
        end else begin
            sync_p0 <= clk_1hz;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
            tick_p3 <= sync_p1 & ~prev_p2;
        end
    end

`ifdef TRAFFIC_NIGHT_MODE_EN
    logic night_p0, night_p1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            night_p0 <= 1'b0;
            night_p1 <= 1'b0;
        end else begin
            night_p0 <= night_mode;
            night_p1 <= night_p0;
        end
    end
    assign night_act = night_p1;
`else
    assign night_act = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= ALL_RED_B;
            sec_q   <= ALLRED_LOAD;
            ns_q    <= LAMP_RED;
            ew_q    <= LAMP_RED;
        end else begin
            phase_q <= phase_d;
            sec_q   <= sec_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
        end
    end

    // FLASH (code 6) counts as illegal here; the night-mode override below claims it when enabled
    always_comb begin
        phase_d = phase_q;
        sec_d   = sec_q;
        if (phase_q > ALL_RED_B) begin
            phase_d = ALL_RED_B;
            sec_d   = ALLRED_LOAD;
        end else if (tick_p3) begin
            if (sec_q > CNT_W'(1)) begin
                sec_d = sec_q - CNT_W'(1);
            end else begin
                phase_d = successor(phase_q);
                sec_d   = duration(successor(phase_q));
            end
        end
        if (night_act) begin
            phase_d = FLASH;
            sec_d   = '0;
        end
    end

    always_comb begin
        ns_d = LAMP_RED;
        ew_d = LAMP_RED;
        case (phase_d)
            NS_GREEN:  ns_d = LAMP_GRN;
            NS_YELLOW: ns_d = LAMP_YEL;
            EW_GREEN:  ew_d = LAMP_GRN;
            EW_YELLOW: ew_d = LAMP_YEL;
            FLASH: begin
                if (phase_q != FLASH) begin
                    ns_d = LAMP_YEL;
                    ew_d = LAMP_YEL;
                end else begin
                    ns_d = tick_p3 ? (ns_q ^ LAMP_YEL) : ns_q;
                    ew_d = tick_p3 ? (ew_q ^ LAMP_YEL) : ew_q;
                end
            end
            default: ;
        endcase
    end

    assign phase    = phase_q;
    assign sec_left = sec_q;
    assign ns_light = ns_q;
    assign ew_light = ew_q;

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Two-direction (north-south / east-west) traffic light sequencer, directly downstream of the 1 Hz clock divider.
- Consumes the divider's slow square wave as a data input, never as a clock. Synchronises it into the clk domain and edge-detects it into a one-cycle second tick.
- Runs the phase sequence from that tick, driving lamp outputs and a seconds-remaining countdown for the display stage.

Parameters:
- GREEN_S, 25: green phase duration in seconds (legal range 1..2^CNT_W-1).
- YELLOW_S, 3: yellow phase duration in seconds (legal range 1..2^CNT_W-1).
- ALLRED_S, 2: all-red clearance duration in seconds (legal range 1..2^CNT_W-1).
- CNT_W, 8: width of the seconds countdown.

Ports:
- clk  in  1  system clock (same clock as the divider).
- rst_n  in  1  reset; asynchronous assert, active-low.
- clk_1hz  in  1  square wave from the clock divider; sampled as data.
- ns_light  out  3  NS lamps, {red, yellow, green}, bit2 = red.
- ew_light  out  3  EW lamps, same encoding.
- sec_left  out  CNT_W  seconds remaining in the current phase.
- phase  out  3  current state encoding (see Behaviour).

Interface decision: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Tick generation:
  - clk_1hz passes through a 2-flop synchroniser, then a third register for edge detection.
  - tick = sync_q & ~prev_q: one clk cycle wide, asserted 3 clk edges after the input rising edge.
  - All three registers reset to 1, so no spurious tick at reset release regardless of the input level.
- States and phase codes:
  - NS_GREEN = 0, NS_YELLOW = 1, ALL_RED_A = 2, EW_GREEN = 3, EW_YELLOW = 4, ALL_RED_B = 5, FLASH = 6 (FLASH exists only with the optional feature).
  - Code 7, and 6 when the feature is off, is illegal. Entering it forces ALL_RED_B with sec_left = ALLRED_S on the next clk.
- Lamps per state:
  - NS_GREEN: ns = 001, ew = 100.
  - NS_YELLOW: ns = 010, ew = 100.
  - EW_GREEN: ns = 100, ew = 001.
  - EW_YELLOW: ns = 100, ew = 010.
  - ALL_RED_A / ALL_RED_B: both 100.
- Reset values (asynchronous): phase = 5 (ALL_RED_B), sec_left = ALLRED_S, ns_light = ew_light = 100.
- Counting on each tick:
  - sec_left > 1: decrement.
  - sec_left == 1: advance NS_GREEN -> NS_YELLOW -> ALL_RED_A -> EW_GREEN -> EW_YELLOW -> ALL_RED_B -> NS_GREEN, loading the new state's duration.
- Timing:
  - All outputs are registered and update on the clk edge where tick is sampled high, i.e. 1 cycle after tick asserts.
  - Without a tick, all outputs hold.
- sec_left never reads 0 outside FLASH. Duration 1 means the state lasts exactly one tick period.
- Safety invariant: outside FLASH, at least one of ns_light[2] / ew_light[2] is 1 at all times, and never both green bits.
- Full cycle length = 2*(GREEN_S + YELLOW_S + ALLRED_S) ticks.
- rst_n asserted mid-phase: immediate return to reset values. Sequencing resumes on the first tick after release.

Optional Feature:
- Macro: TRAFFIC_NIGHT_MODE_EN.
- Defined:
  - Adds input night_mode (1 bit), passed through its own 2-flop synchroniser (reset 0).
  - Synced night_mode high from any state: next clk enters FLASH with ns = ew = 010 and sec_left = 0. Each subsequent tick toggles both yellow bits; red and green stay 0.
  - Synced night_mode low while in FLASH: next clk enters ALL_RED_B with sec_left = ALLRED_S, then normal sequencing resumes.
  - Night mode takes priority over a same-cycle tick.
- Undefined: no night_mode port, no FLASH state. Behaviour is exactly the base sequence.

Test Plan:
All tests use GREEN_S = 4, YELLOW_S = 2, ALLRED_S = 1, CNT_W = 8, and clk_1hz toggled every 10 clk (period 20).
- Reset and first tick:
  - Stimulus: release rst_n with clk_1hz high.
  - Response: no tick; phase = 5, sec_left = 1, both 100 until the next rising edge. Then on tick+1: phase = 0, sec_left = 4, ns = 001, ew = 100.
- Full cycle:
  - Phase entries from tick 1: NS_GREEN at tick 1, NS_YELLOW at tick 5 (sec_left = 2), ALL_RED_A at tick 7, EW_GREEN at tick 8, EW_YELLOW at tick 12, ALL_RED_B at tick 14, NS_GREEN at tick 15.
  - sec_left decrements 4, 3, 2, 1 within each green phase.
- Tick latency:
  - Stimulus: clk_1hz rising edge.
  - Response: outputs change exactly 4 clk edges later. Holding clk_1hz constant for 100 clk produces no output change.
- Reset mid-operation:
  - Stimulus: assert rst_n during EW_GREEN with sec_left = 3, between clk edges.
  - Response: outputs go to phase 5 / 100 / 100 / sec_left = 1 immediately, without waiting for clk.
- Safety scoreboard:
  - Run 20 full cycles.
  - Response: no cycle with both red bits 0 and no cycle with both green bits 1.
- (TRAFFIC_NIGHT_MODE_EN) Night mode:
  - Stimulus: raise night_mode during NS_GREEN.
  - Response: FLASH 3 clk later with yellow = 010 on both directions, toggling each tick. Lower night_mode: ALL_RED_B with sec_left = 1, then NS_GREEN on the next tick.
